// File: rtl/iot_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the IoT filter-engine source driver.
package iot_pkg;

  localparam int unsigned BLK_W         = 128;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BYTES_PER_BLK = 16;
  localparam int unsigned CNT_W         = $clog2(BYTES_PER_BLK);
  localparam int unsigned FN_W          = 3;
  localparam int unsigned SENT_W        = 16;

  // Engine function codes
  localparam logic [FN_W-1:0] ENCRYPT  = 3'd1;
  localparam logic [FN_W-1:0] DECRYPT  = 3'd2;
  localparam logic [FN_W-1:0] CRC_GEN  = 3'd3;
  localparam logic [FN_W-1:0] TOP2MAX  = 3'd4;
  localparam logic [FN_W-1:0] LAST2MIN = 3'd5;

  // Transmit FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } tx_state_t;

endpackage

// File: rtl/iot_sync_fifo.sv
`timescale 1ns/1ps
// Single-clock FIFO with wrap-bit pointers; head is the oldest entry.
module iot_sync_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage and pointers; storage cleared so the head reads zero out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/iot_stream_tx.sv
`timescale 1ns/1ps
// Buffers 128-bit blocks, streams them LSB-byte first to the filter engine,
// and queues the engine results for a downstream consumer.
module iot_stream_tx
  import iot_pkg::*;
#(
  parameter int unsigned BLK_DEPTH = 4,
  parameter int unsigned RES_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FN_W-1:0]    fn_cfg,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLK_W-1:0]   blk_data,
  output logic [FN_W-1:0]    fn_sel,
  input  logic               busy,
  output logic               in_en,
  output logic [BYTE_W-1:0]  iot_in,
  input  logic               valid,
  input  logic [BLK_W-1:0]   iot_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [BLK_W-1:0]   res_data,
  output logic               res_ovf,
  output logic [SENT_W-1:0]  blk_sent
);

  tx_state_t          state;
  tx_state_t          state_nxt;
  logic [BLK_W-1:0]   shift_reg;
  logic [CNT_W-1:0]   byte_cnt;
  logic               fn_latched;

  logic               blk_full;
  logic               blk_empty;
  logic [BLK_W-1:0]   blk_head;
  logic               blk_push;
  logic               blk_pop;
  logic               load;
  logic               shift;
  logic               sent_inc;

  logic               res_full;
  logic               res_empty;
  logic               res_pop;

  assign blk_ready = !blk_full;
  assign blk_push  = blk_valid && !blk_full;

  iot_sync_fifo #(.WIDTH(BLK_W), .DEPTH(BLK_DEPTH)) u_blk_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (blk_push),
    .pop   (blk_pop),
    .data  (blk_data),
    .full  (blk_full),
    .empty (blk_empty),
    .head  (blk_head)
  );

  assign res_pop   = res_ready && !res_empty;
  assign res_valid = !res_empty;

  iot_sync_fifo #(.WIDTH(BLK_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid),
    .pop   (res_pop),
    .data  (iot_out),
    .full  (res_full),
    .empty (res_empty),
    .head  (res_data)
  );

  // Byte strobe follows the engine's busy directly while sending
  assign in_en  = (state == ST_SEND) && !busy;
  assign iot_in = shift_reg[BYTE_W-1:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath controls; last byte reloads directly when a block waits
  always_comb begin
    state_nxt = state;
    blk_pop   = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    sent_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!blk_empty) begin
          blk_pop   = 1'b1;
          load      = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: begin
        if (!busy) begin
          shift = 1'b1;
          if (byte_cnt == CNT_W'(BYTES_PER_BLK - 1)) begin
            sent_inc = 1'b1;
            if (!blk_empty) begin
              blk_pop = 1'b1;
              load    = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift register and byte counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (load) begin
      shift_reg <= blk_head;
      byte_cnt  <= '0;
    end else if (shift) begin
      shift_reg <= shift_reg >> BYTE_W;
      byte_cnt  <= byte_cnt + CNT_W'(1);
    end
  end

  // Function select captured once on the first accepted block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fn_sel     <= '0;
      fn_latched <= 1'b0;
    end else if (blk_push && !fn_latched) begin
      fn_sel     <= fn_cfg;
      fn_latched <= 1'b1;
    end
  end

  // Completed-block counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           blk_sent <= '0;
    else if (sent_inc) blk_sent <= blk_sent + SENT_W'(1);
  end

  // Sticky overflow when a result arrives into a full FIFO that is not draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               res_ovf <= 1'b0;
    else if (valid && res_full && !res_pop) res_ovf <= 1'b1;
  end

endmodule

// File: tb/tb_iot_stream_tx.sv
`timescale 1ns/1ps
// Directed bench for iot_stream_tx with byte and result scoreboards.
module tb_iot_stream_tx;
  import iot_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   fn_cfg;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic [2:0]   fn_sel;
  logic         busy;
  logic         in_en;
  logic [7:0]   iot_in;
  logic         valid;
  logic [127:0] iot_out;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         res_ovf;
  logic [15:0]  blk_sent;

  int total = 0;
  int bad   = 0;

  logic [7:0]   exp_bytes[$];
  logic [127:0] exp_res[$];

  localparam logic [127:0] CNT_BLK = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] RES_A   = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] RES_B   = 128'hBBBB_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
  localparam logic [127:0] RES_C   = 128'hCCCC_0123_4567_89AB_CDEF_0F1E_2D3C_4B5A;

  iot_stream_tx #(.BLK_DEPTH(4), .RES_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .fn_cfg    (fn_cfg),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .fn_sel    (fn_sel),
    .busy      (busy),
    .in_en     (in_en),
    .iot_in    (iot_in),
    .valid     (valid),
    .iot_out   (iot_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .blk_sent  (blk_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte scoreboard: every accepted strobe must match the next queued byte
  always @(negedge clk) begin
    if (in_en === 1'b1) begin
      if (exp_bytes.size() == 0) chk("unexpected_byte", 128'(in_en), 128'(0));
      else                       chk("byte", 128'(iot_in), 128'(exp_bytes.pop_front()));
    end
  end

  // Result scoreboard: every accepted result must match the next queued result
  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_res.size() == 0) chk("unexpected_res", 128'(res_valid), 128'(0));
      else                     chk("res", res_data, exp_res.pop_front());
    end
  end

  task automatic push_blk(input logic [127:0] d);
    @(posedge clk); #1;
    chk("blk_ready_pre", 128'(blk_ready), 128'(1));
    blk_valid = 1'b1;
    blk_data  = d;
    for (int k = 0; k < 16; k++) exp_bytes.push_back(d[8*k +: 8]);
    @(posedge clk); #1;
    blk_valid = 1'b0;
  endtask

  task automatic wait_first_byte(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_en !== 1'b1 && n < 20);
    chk(tag, 128'(in_en), 128'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_bytes.size() != 0 || in_en === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 128'(exp_bytes.size()), 128'(0));
  endtask

  initial begin
    logic [127:0] d;
    rst = 1'b1; fn_cfg = CRC_GEN; blk_valid = 1'b0; blk_data = '0;
    busy = 1'b0; valid = 1'b0; iot_out = '0; res_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_blk_ready", 128'(blk_ready), 128'(1));
    chk("rst_fn_sel",    128'(fn_sel),    128'(0));
    chk("rst_in_en",     128'(in_en),     128'(0));
    chk("rst_iot_in",    128'(iot_in),    128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_res_data",  res_data,        128'(0));
    chk("rst_res_ovf",   128'(res_ovf),   128'(0));
    chk("rst_blk_sent",  128'(blk_sent),  128'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Single block: IDLE, LOAD, then 16 contiguous bytes
    push_blk(CNT_BLK);
    @(negedge clk);
    chk("t1_idle_in_en", 128'(in_en), 128'(0));
    @(negedge clk);
    chk("t1_load_in_en",  128'(in_en),  128'(0));
    chk("t1_load_iot_in", 128'(iot_in), 128'(0));
    chk("t1_fn_sel",      128'(fn_sel), 128'(CRC_GEN));
    repeat (16) begin
      @(negedge clk);
      chk("t1_run", 128'(in_en), 128'(1));
    end
    @(negedge clk);
    chk("t1_end_in_en", 128'(in_en),    128'(0));
    chk("t1_blk_sent",  128'(blk_sent), 128'(1));

    // Five blocks queued under busy: FIFO fills, then 80 strobes with no gap
    @(posedge clk); #1;
    busy   = 1'b1;
    fn_cfg = LAST2MIN;
    for (int i = 0; i < 5; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      chk("t2_ready", 128'(blk_ready), 128'(1));
      blk_valid = 1'b1;
      blk_data  = d;
      for (int k = 0; k < 16; k++) exp_bytes.push_back(d[8*k +: 8]);
      @(posedge clk); #1;
    end
    blk_valid = 1'b0;
    chk("t2_full",   128'(blk_ready), 128'(0));
    chk("t2_fn_sel", 128'(fn_sel),    128'(CRC_GEN));
    busy = 1'b0;
    repeat (80) begin
      @(negedge clk);
      chk("t2_run", 128'(in_en), 128'(1));
    end
    @(negedge clk);
    chk("t2_end_in_en", 128'(in_en),    128'(0));
    chk("t2_blk_sent",  128'(blk_sent), 128'(6));
    chk("t2_ready_end", 128'(blk_ready), 128'(1));

    // busy stall while byte 5 is presented
    push_blk(CNT_BLK);
    wait_first_byte("t3_start");
    repeat (4) begin
      @(negedge clk);
      chk("t3_pre", 128'(in_en), 128'(1));
    end
    @(posedge clk); #1 busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_in_en",  128'(in_en),  128'(0));
      chk("t3_stall_iot_in", 128'(iot_in), 128'(8'h05));
    end
    @(posedge clk); #1 busy = 1'b0;
    repeat (11) begin
      @(negedge clk);
      chk("t3_post", 128'(in_en), 128'(1));
    end
    @(negedge clk);
    chk("t3_end_in_en", 128'(in_en),    128'(0));
    chk("t3_blk_sent",  128'(blk_sent), 128'(7));

    // Result FIFO overflow and drain
    @(posedge clk); #1;
    valid = 1'b1; iot_out = RES_A; exp_res.push_back(RES_A);
    @(posedge clk); #1;
    iot_out = RES_B; exp_res.push_back(RES_B);
    @(posedge clk); #1;
    iot_out = RES_C;
    @(posedge clk); #1;
    valid = 1'b0; iot_out = '0;
    chk("t4_ovf",       128'(res_ovf),   128'(1));
    chk("t4_res_valid", 128'(res_valid), 128'(1));
    chk("t4_head",      res_data,        RES_A);
    @(negedge clk);
    chk("t4_head_hold", res_data, RES_A);
    @(posedge clk); #1 res_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("t4_empty",     128'(res_valid),      128'(0));
    chk("t4_sb_empty",  128'(exp_res.size()), 128'(0));
    chk("t4_ovf_hold",  128'(res_ovf),        128'(1));

    // Reset in the middle of a block
    push_blk(CNT_BLK);
    wait_first_byte("t5_start");
    repeat (7) begin
      @(negedge clk);
      chk("t5_pre", 128'(in_en), 128'(1));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_bytes.delete();
    #1;
    chk("t5_in_en",     128'(in_en),     128'(0));
    chk("t5_blk_sent",  128'(blk_sent),  128'(0));
    chk("t5_blk_ready", 128'(blk_ready), 128'(1));
    chk("t5_res_ovf",   128'(res_ovf),   128'(0));
    chk("t5_fn_sel",    128'(fn_sel),    128'(0));
    chk("t5_iot_in",    128'(iot_in),    128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("t5_quiet", 128'(in_en), 128'(0));
    end
    fn_cfg = DECRYPT;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_blk(d);
    wait_drain();
    chk("t5_new_sent",   128'(blk_sent), 128'(1));
    chk("t5_new_fn_sel", 128'(fn_sel),   128'(DECRYPT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
